// File: rtl/nsum_pkg.sv
// rtl/nsum_pkg.sv - shared types and default widths for the triangular-number engine
// Contents: FSM state type, default operand/result widths.
package nsum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } nsum_state_t;

  localparam int N_W_DEF   = 3;
  localparam int SUM_W_DEF = 4;

endpackage

// File: rtl/nsum_datapath.sv
// rtl/nsum_datapath.sv - down-counter, accumulator and result register for nsum
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   load_i           capture n_i into the counter and clear the accumulator
//   step_i           add the current counter value to the accumulator, count down
//   finish_i         update the result register (0 when finishing on a load)
//   n_i              requested upper bound
//   last_term_o      counter equals 1 (the term being added is the final one)
//   zero_o           requested bound is zero
//   sum_o            result register
module nsum_datapath
  import nsum_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             finish_i,
  input  logic [N_W-1:0]   n_i,
  output logic             last_term_o,
  output logic             zero_o,
  output logic [SUM_W-1:0] sum_o
);

  logic [N_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] acc_plus_cnt;

  // Widened addition wraps naturally modulo 2**SUM_W.
  assign acc_plus_cnt = acc_q + SUM_W'(cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    sum_d = sum_q;
    if (load_i) begin
      cnt_d = n_i;
      acc_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q - 1'b1;
      acc_d = acc_plus_cnt;
    end
    // Finishing together with a load only happens for N=0, whose result is 0;
    // otherwise the final term is folded in directly so sum is ready in DONE.
    if (finish_i) begin
      sum_d = load_i ? '0 : acc_plus_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign last_term_o = (cnt_q == N_W'(1));
  assign zero_o      = (n_i == '0);
  assign sum_o       = sum_q;

endmodule

// File: rtl/nsum.sv
// rtl/nsum.sv - serial triangular-number engine (sum = 1+2+...+N, one term per cycle)
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   N          requested upper bound, sampled only when accepted in IDLE
//   N_valid    request strobe
//   sum        last completed result (modulo 2**SUM_W)
//   sum_valid  one-cycle strobe marking a new result
module nsum
  import nsum_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_W-1:0]   N,
  input  logic             N_valid,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid
);

  nsum_state_t state_q, state_d;
  logic        sum_valid_q;
  logic        load, step, finish;
  logic        last_term, zero;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (N_valid) begin
          load = 1'b1;
          if (zero) begin
            finish  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last_term) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sum_valid is a flop mirroring "next state is DONE", so it is high exactly
  // while the FSM sits in DONE and never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_valid_q <= (state_d == DONE);
    end
  end

  assign sum_valid = sum_valid_q;

  nsum_datapath #(
    .N_W  (N_W),
    .SUM_W(SUM_W)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .step_i     (step),
    .finish_i   (finish),
    .n_i        (N),
    .last_term_o(last_term),
    .zero_o     (zero),
    .sum_o      (sum)
  );

endmodule

// File: tb/tb_nsum.sv
// tb/tb_nsum.sv - self-checking bench for nsum against a closed-form reference
module tb_nsum;
  import nsum_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] N;
  logic       N_valid;
  logic [3:0] sum;
  logic       sum_valid;

  int passed = 0;
  int total  = 0;

  nsum dut (
    .clk      (clk),
    .reset    (reset),
    .N        (N),
    .N_valid  (N_valid),
    .sum      (sum),
    .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Closed form of 1+..+n, reduced modulo 16.
  function automatic int model(input int n);
    return (n * (n + 1) / 2) % 16;
  endfunction

  // junk_mode: 0 = quiet while busy, 1 = pulse N=4 once, 2 = random N_valid noise
  task automatic run_job(input int n, input int junk_mode, input string tag);
    int  c;
    bit  seen;
    int  exp_sum;
    exp_sum = model(n);
    N = 3'(n);
    N_valid = 1'b1;
    tick();
    N_valid = 1'b0;
    c = 0;
    seen = 0;
    while (!seen && c <= 20) begin
      if (sum_valid === 1'b1) begin
        seen = 1;
        N_valid = 1'b0;
      end else begin
        if (junk_mode == 1) begin
          N_valid = (c == 1);
          N = 3'd4;
        end else if (junk_mode == 2) begin
          N_valid = 1'($urandom_range(0, 1));
          N = 3'($urandom_range(0, 7));
        end
        tick();
        c++;
      end
    end
    N_valid = 1'b0;
    check({tag, " latency"}, c, n);
    check({tag, " sum"}, int'(sum), exp_sum);
    tick();
    check({tag, " valid_one_cycle"}, int'(sum_valid), 0);
    check({tag, " sum_hold"}, int'(sum), exp_sum);
  endtask

  initial begin
    int vcount;
    int n;
    reset   = 1'b1;
    N       = '0;
    N_valid = 1'b0;
    tick();
    check("reset sum", int'(sum), 0);
    check("reset sum_valid", int'(sum_valid), 0);
    check("reset state", int'(dut.state_q), int'(IDLE));
    reset = 1'b0;
    tick();

    // N=5 with an N=4 request during BUSY that must be dropped
    run_job(5, 1, "n5_ignore");
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (sum_valid === 1'b1) vcount++;
      tick();
    end
    check("ignored request no extra valid", vcount, 0);
    check("sum still 15", int'(sum), 15);
    run_job(4, 0, "n4");

    // Boundaries, issued back-to-back
    run_job(0, 0, "n0");
    run_job(1, 0, "n1");
    run_job(7, 0, "n7_wrap");
    run_job(6, 0, "n6_wrap");

    // Reset in the middle of an N=7 job, after three steps
    N = 3'd7;
    N_valid = 1'b1;
    tick();
    N_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset sum", int'(sum), 0);
    check("midreset sum_valid", int'(sum_valid), 0);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (sum_valid === 1'b1) vcount++;
      tick();
    end
    check("midreset no valid", vcount, 0);
    check("midreset sum stays 0", int'(sum), 0);
    run_job(3, 0, "after_reset_n3");

    // Randomized jobs with random gaps and noise on N_valid while busy
    for (int j = 0; j < 24; j++) begin
      n = $urandom_range(0, 7);
      run_job(n, (j % 2 == 0) ? 2 : 0, $sformatf("rand%0d_n%0d", j, n));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
